bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock) sitting directly
//  upstream of the per-digit 7-segment decoders on the board HEX displays. Accepts a binary value
//  on a start pulse and produces DIGITS registered 4-bit BCD nibbles. Each nibble drives one
//  decoder's 4-bit input, giving a decimal readout instead of hex.
// PARAMETERS
//  IN_WIDTH   20  width of binary input
//  DIGITS     6   number of BCD output digits (one per HEX display)
// PORTS
//  clk         in   1             system clock; all state updates on posedge
//  reset       in   1             asynchronous, active-high reset
//  start       in   1             request conversion of bin_in (single-cycle pulse or level)
//  bin_in      in   IN_WIDTH      binary value, sampled on the edge that accepts start
//  busy        out  1             conversion in progress; start ignored while high
//  done        out  1             one-cycle pulse: bcd_out/overflow just updated
//  overflow    out  1             last accepted value >= 10**DIGITS
//  bcd_out     out  4*DIGITS      digit k at [4k+3:4k], k=0 least significant
//  blank_mask  out  DIGITS        only with BCD_LZ_BLANK_EN; bit k=1 -> digit k is a leading zero
// BEHAVIOUR
//  Reset: one clock; async active-high. Asserting reset clears all state immediately: FSM->IDLE,
//   busy=0, done=0, overflow=0, bcd_out=0, blank_mask={DIGITS-1{1'b1}},1'b0 (all but digit 0).
//  FSM states: IDLE, CONVERT, DONE.
//   IDLE: start=1 at edge N -> latch bin_in into shift reg, clear BCD scratch, bit count=IN_WIDTH,
//    state->CONVERT, busy=1 from edge N.
//   CONVERT: each edge: every scratch digit >=5 gets +3 (all digits in parallel), then shift
//    {scratch,shreg} left 1. Count decrements; after IN_WIDTH edges -> DONE.
//   DONE: edge N+IN_WIDTH+1 loads bcd_out (and blank_mask) from scratch and sets done=1 for
//    exactly one cycle; busy=0 on the same edge; state->IDLE.
//  Latency: start sampled at edge N -> done high during cycle following edge N+IN_WIDTH+1
//   (21 cycles for default). Throughput: one conversion per IN_WIDTH+2 cycles.
//  start while busy=1 (CONVERT or DONE): ignored, not queued. start held high: new conversion
//   accepted on the first IDLE edge after done.
//  Overflow: compare bin_in >= 10**DIGITS at acceptance (localparam, computed in IN_WIDTH+1 bits).
//   If set: conversion still runs for timing uniformity, but DONE loads every digit with 4'h9 and
//   overflow=1. Otherwise overflow=0. overflow updates only at DONE, together with bcd_out.
//  bcd_out/overflow/blank_mask hold their last values between conversions; never show partial
//   results. Scratch is DIGITS*4 bits; carry out of top digit is discarded (covered by overflow).
//  Reset mid-CONVERT: conversion abandoned, no done pulse, outputs to reset values.
// CONFIGURATION
//  `BCD_LZ_BLANK_EN defined: blank_mask registered at DONE; bit k=1 iff digits k..DIGITS-1 are all
//   0 and k!=0 (digit 0 never blanked; overflow -> mask all 0). Downstream blanks those displays.
//  Not defined: blank_mask port absent; no extra logic.
// STRUCTURE
//  Package bcd_pkg: typedef enum {IDLE,CONVERT,DONE} bcd_state_t; localparam DIGIT_W=4;
//   function pow10(n) for the overflow limit.
//  Sub-module bcd_add3: combinational 4-bit in -> (in>=5 ? in+3 : in); instantiated DIGITS times
//   via generate. Counter width $clog2(IN_WIDTH+1).
// TESTING
//  1 bin_in=0, start pulse -> done 21 cycles later, bcd_out=24'h000000, overflow=0.
//  2 bin_in=123456 -> bcd_out=24'h123456; bin_in=999999 -> 24'h999999, overflow=0.
//  3 bin_in=1000000 and 20'hFFFFF -> bcd_out=24'h999999, overflow=1, done still at +21 cycles.
//  4 start at edge N, second start (bin_in=7) at N+5 -> ignored; one done, result from first value.
//  5 reset asserted at cycle 10 of conversion -> busy=0, bcd_out=0 asynchronously, no done pulse;
//    next start converts normally.
//  6 (`BCD_LZ_BLANK_EN) bin_in=42 -> bcd_out=24'h000042, blank_mask=6'b111100; bin_in=0 ->
//    6'b111110; without macro the port is absent and the bench compiles.
//  Scoreboard: random bin_in (1000 values, start held high) vs. reference divide/mod model.

Source files
------------

// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and helpers for the sequential binary-to-BCD converter.
//   - bcd_state_t : converter FSM states (IDLE, CONVERT, DONE)
//   - DIGIT_W     : width of one BCD digit
//   - pow10(n)    : 10**n, used at elaboration time for the overflow limit
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
//   Combinational "add 3 if >= 5" correction for one BCD digit of the
//   shift-and-add-3 converter.
//   Ports:
//     d_in  : current scratch digit
//     d_out : d_in + 3 when d_in >= 5, else d_in
// ----------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    always_comb begin
        if (d_in >= DIGIT_W'(5)) begin
            d_out = d_in + DIGIT_W'(3);
        end else begin
            d_out = d_in;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
//   clock) feeding per-digit 7-segment decoders.
//
//   Optional feature: define BCD_LZ_BLANK_EN to add the blank_mask output
//   (leading-zero flags, registered together with bcd_out).
//
//   Ports:
//     clk        : system clock, all state updates on posedge
//     reset      : asynchronous, active-high reset
//     start      : request conversion of bin_in (pulse or level)
//     bin_in     : binary value, sampled on the edge that accepts start
//     busy       : conversion in progress; start ignored while high
//     done       : one-cycle pulse, bcd_out/overflow just updated
//     overflow   : last accepted value >= 10**DIGITS
//     bcd_out    : digit k at [4k+3:4k], k=0 least significant
//     blank_mask : (BCD_LZ_BLANK_EN only) bit k=1 -> digit k is a leading zero
//     state_dbg  : current FSM state, for observation only
//
//   Handshake: start is accepted on a rising edge where the FSM is IDLE
//   (busy=0). While busy=1 start is ignored, never queued. A start held high
//   is accepted again on the first IDLE edge after done.
//
//   Timing: accept at edge N, IN_WIDTH shift edges N+1..N+IN_WIDTH, results
//   loaded at edge N+IN_WIDTH+1 with done high for the following cycle.
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 20,
    parameter int DIGITS   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       bin_in,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BCD_LZ_BLANK_EN
    output logic [DIGITS-1:0]         blank_mask,
`endif
    output bcd_state_t                state_dbg
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int LIM_W = IN_WIDTH + 1;

    // If 10**DIGITS does not fit in IN_WIDTH+1 bits no input can reach it,
    // so the compare is disabled rather than done against a truncated limit.
    localparam logic [63:0]      LIMIT_FULL = pow10(DIGITS);
    localparam bit               LIMIT_FITS = (LIMIT_FULL < (64'd1 << LIM_W));
    localparam logic [LIM_W-1:0] LIMIT      = LIM_W'(LIMIT_FULL);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    bcd_state_t          state_q, state_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [SCR_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   lz_mask;
`endif

    logic [SCR_W-1:0]    scratch_adj;

    // Per-digit add-3 correction, all digits in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONVERT;
            // cnt_q reaches 1 on the last shift edge
            CONVERT: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        state_dbg = state_q;
        done      = done_q;
        overflow  = ovf_q;
        bcd_out   = bcd_q;
`ifdef BCD_LZ_BLANK_EN
        blank_mask = blank_q;
`endif
    end

`ifdef BCD_LZ_BLANK_EN
    // Digit k is a leading zero when it and every digit above it are zero;
    // digit 0 always stays lit and an overflow readout is never blanked.
    always_comb begin
        logic zero_above;
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (scratch_q[k*DIGIT_W +: DIGIT_W] == '0);
            lz_mask[k] = zero_above && (k != 0) && !ovf_pend_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
`ifdef BCD_LZ_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_WIDTH);
                    ovf_pend_d = LIMIT_FITS && ({1'b0, bin_in} >= LIMIT);
                end
            end
            CONVERT: begin
                // Adjust, then shift {scratch, shreg} left by one.
                scratch_d  = {scratch_adj[SCR_W-2:0], shreg_q[IN_WIDTH-1]};
                shreg_d    = {shreg_q[IN_WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q - CNT_W'(1);
                // A carry out of the top digit only occurs for out-of-range
                // inputs, so folding it in never changes a valid result.
                ovf_pend_d = ovf_pend_q | scratch_adj[SCR_W-1];
            end
            DONE: begin
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
`ifdef BCD_LZ_BLANK_EN
                blank_d = lz_mask;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
`ifdef BCD_LZ_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq (default IN_WIDTH=20, DIGITS=6).
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
//   The blank_mask checks are compiled in only when BCD_LZ_BLANK_EN is defined.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    localparam int IN_WIDTH = 20;
    localparam int DIGITS   = 6;
    localparam int LATENCY  = IN_WIDTH + 1;   // posedges from accept edge to done
    localparam int PERIOD   = IN_WIDTH + 2;   // back-to-back with start held high

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [IN_WIDTH-1:0] bin_in = '0;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd_out;
    bcd_state_t          state_dbg;
`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]   blank_mask;
`endif

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .bcd_out    (bcd_out),
`ifdef BCD_LZ_BLANK_EN
        .blank_mask (blank_mask),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain decimal arithmetic) ----------------
    function automatic bit ref_ovf(input int unsigned v);
        return v >= 1000000;
    endfunction

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned p;
        if (ref_ovf(v)) return 24'h999999;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_mask(input int unsigned v);
        logic [5:0] m;
        int unsigned p;
        m = '0;
        if (ref_ovf(v)) return m;
        p = 10;
        for (int k = 1; k < DIGITS; k++) begin
            m[k] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock and land on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for done; cycles = posedges consumed. bin_in is scrambled
    // while waiting to show it is only sampled at acceptance.
    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < budget) begin
            step();
            cycles++;
            if (done === 1'b1) begin
                seen = 1'b1;
                return;
            end
            bin_in = 20'($urandom);
        end
    endtask

    // Single-pulse conversion with full result check.
    task automatic run_vector(input string tag, input int unsigned v,
                              input logic [23:0] e_bcd, input logic e_ovf,
                              input logic [5:0] e_mask);
        int cyc;
        bit seen;
        start  = 1'b1;
        bin_in = 20'(v);
        step();                       // accept edge N
        start  = 1'b0;
        check({tag, ".busy"}, busy, 1'b1);
        wait_done(LATENCY + 10, cyc, seen);
        check({tag, ".done_seen"}, seen, 1'b1);
        check({tag, ".latency"}, cyc, LATENCY);
        check({tag, ".bcd"}, bcd_out, e_bcd);
        check({tag, ".ovf"}, overflow, e_ovf);
        check({tag, ".busy_at_done"}, busy, 1'b0);
`ifdef BCD_LZ_BLANK_EN
        check({tag, ".mask"}, blank_mask, e_mask);
`else
        if (e_mask != ref_mask(v)) check({tag, ".table_mask"}, e_mask, ref_mask(v));
`endif
        step();
        check({tag, ".done_pulse_width"}, done, 1'b0);
        check({tag, ".bcd_hold"}, bcd_out, e_bcd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [19:0] bin;
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  mask;
    } vec_t;

    vec_t vecs[10];

    // ---------------- scoreboard for random phase ----------------
    logic [30:0] exp_q[$];   // {mask, ovf, bcd}

    function automatic logic [30:0] pack_exp(input int unsigned v);
        return {ref_mask(v), ref_ovf(v), ref_bcd(v)};
    endfunction

    function automatic int unsigned rand_value();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 99);
            1:       return $urandom_range(999_990, 1_000_010);
            default: return $urandom_range(0, 20'hFFFFF);
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int ndone;
        int first_at;
        bit seen;
        int unsigned v;
        logic [30:0] e;
        logic [23:0] bcd_first;

        vecs[0] = '{20'd0,       24'h000000, 1'b0, 6'b111110};
        vecs[1] = '{20'd123456,  24'h123456, 1'b0, 6'b000000};
        vecs[2] = '{20'd999999,  24'h999999, 1'b0, 6'b000000};
        vecs[3] = '{20'd1000000, 24'h999999, 1'b1, 6'b000000};
        vecs[4] = '{20'hFFFFF,   24'h999999, 1'b1, 6'b000000};
        vecs[5] = '{20'd42,      24'h000042, 1'b0, 6'b111100};
        vecs[6] = '{20'd1,       24'h000001, 1'b0, 6'b111110};
        vecs[7] = '{20'd10,      24'h000010, 1'b0, 6'b111100};
        vecs[8] = '{20'd100000,  24'h100000, 1'b0, 6'b000000};
        vecs[9] = '{20'd90817,   24'h090817, 1'b0, 6'b100000};

        // ---- reset values (checked asynchronously, between edges) ----
        #3 reset = 1'b1;
        #1;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.bcd", bcd_out, 24'h0);
        check("rst.state", state_dbg, IDLE);
`ifdef BCD_LZ_BLANK_EN
        check("rst.mask", blank_mask, 6'b111110);
`endif
        step();
        step();
        reset = 1'b0;
        step();

        // ---- table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].mask);
        end

        // ---- second start while busy is ignored ----
        start  = 1'b1;
        bin_in = 20'd314159;
        step();                       // edge N
        start  = 1'b0;
        cyc    = 1;
        repeat (4) begin
            step();
            cyc++;
        end
        start  = 1'b1;                // drives edge N+5
        bin_in = 20'd7;
        step();
        cyc++;
        start  = 1'b0;
        ndone     = 0;
        first_at  = -1;
        bcd_first = '0;
        repeat (45) begin
            step();
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                if (first_at < 0) begin
                    first_at  = cyc - 1;
                    bcd_first = bcd_out;
                end
            end
        end
        check("ignore.done_count", ndone, 1);
        check("ignore.latency", first_at, LATENCY);
        check("ignore.bcd", bcd_first, ref_bcd(314159));
        check("ignore.bcd_hold", bcd_out, ref_bcd(314159));

        // ---- reset in the middle of a conversion ----
        start  = 1'b1;
        bin_in = 20'd500000;
        step();
        start  = 1'b0;
        repeat (9) step();            // conversion cycle 10
        check("midrst.busy_before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst.busy", busy, 1'b0);
        check("midrst.bcd", bcd_out, 24'h0);
        check("midrst.ovf", overflow, 1'b0);
        check("midrst.done", done, 1'b0);
        check("midrst.state", state_dbg, IDLE);
`ifdef BCD_LZ_BLANK_EN
        check("midrst.mask", blank_mask, 6'b111110);
`endif
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            step();
            if (done === 1'b1) ndone++;
        end
        check("midrst.no_done", ndone, 0);
        check("midrst.bcd_still_zero", bcd_out, 24'h0);
        run_vector("after_rst", 271828, 24'h271828, 1'b0, 6'b000000);

        // ---- random back-to-back conversions with start held high ----
        v      = rand_value();
        start  = 1'b1;
        bin_in = 20'(v);
        exp_q.push_back(pack_exp(v));
        for (int i = 0; i < 1000; i++) begin
            wait_done(PERIOD + 10, cyc, seen);
            check("rnd.done_seen", seen, 1'b1);
            if (!seen) break;
            check("rnd.period", cyc, PERIOD);
            e = exp_q.pop_front();
            check("rnd.bcd", bcd_out, e[23:0]);
            check("rnd.ovf", overflow, e[24]);
`ifdef BCD_LZ_BLANK_EN
            check("rnd.mask", blank_mask, e[30:25]);
`endif
            if (i < 999) begin
                v      = rand_value();
                bin_in = 20'(v);      // sampled on the very next edge
                exp_q.push_back(pack_exp(v));
            end else begin
                start = 1'b0;
            end
        end
        step();
        step();
        check("end.busy", busy, 1'b0);
        check("end.queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
